ps2_transmitter: RTL and testbench
==================================

Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter, the send side paired with the existing PS/2 receiver on the keyboard port (EXT_P[7] clock, EXT_P[4] data). It accepts one byte from the CPU I/O write path and runs the full PS/2 host request-to-send sequence: inhibit, start bit, 8 data bits, odd parity, stop, then device ACK check. The byte is typically a keyboard command such as 0xED (set LEDs) or 0xFF (reset). The top level turns the two open-drain enables into bidirectional pins, and `busy` gates the receiver so it ignores device clocks during a transmission.

Parameters:
- CLK_HZ, 50000000, frequency of clk in Hz.
- INHIBIT_US, 120, time the host holds PS/2 clock low before the start bit.
- START_TO_US, 15000, maximum time from clock release to the first device falling edge.
- XFER_TO_US, 2000, maximum time from the first device falling edge to the ACK edge.

Ports:
- clk, in, 1: 50 MHz system clock.
- n_res, in, 1: asynchronous active-low reset.
- clk0, in, 1: CPU-clock phase qualifier; a write is accepted only when clk0=1.
- wr_stb, in, 1: write request, decoded from nIORQ/nWR/port select by the top level.
- wr_data, in, 8: byte to send.
- ps2_clock_in, in, 1: raw PS/2 clock pin level (asynchronous).
- ps2_data_in, in, 1: raw PS/2 data pin level (asynchronous).
- ps2_clock_oe, out, 1: 1 drives the clock pin low; 0 releases it to high-Z.
- ps2_data_oe, out, 1: 1 drives the data pin low; 0 releases it to high-Z.
- busy, out, 1: transfer in progress.
- done, out, 1: one-clk pulse when a transfer ends (success, ACK error or timeout).
- ack_err, out, 1: sticky; device did not ACK.
- timeout, out, 1: sticky; a timeout expired.

Behaviour:
- Reset (asynchronous, while n_res=0):
  - All outputs are 0, so both lines are released.
  - State goes to IDLE and all counters clear.
  - Reset mid-transfer releases both lines on the same edge, with no completion pulse.
- Input conditioning:
  - ps2_clock_in and ps2_data_in each pass through a 2-FF synchronizer.
  - A falling edge is synced-clock previous=1, current=0.
  - Data is sampled from the synced value in the same cycle as the edge.
- Write acceptance:
  - Condition is wr_stb & clk0 in IDLE.
  - On acceptance: latch wr_data, compute par = ~^wr_data, clear ack_err and timeout, assert busy next clk, enter INHIBIT.
  - wr_stb while busy is ignored, with no flag change.
- Cycle counts:
  - N_INH = CLK_HZ/1e6*INHIBIT_US (6000 at defaults).
  - N_ST = CLK_HZ/1e6*START_TO_US (750000).
  - N_XF = CLK_HZ/1e6*XFER_TO_US (100000).
  - One shared down-counter is sized to ceil(log2(max count + 1)) bits.
- INHIBIT:
  - clock_oe=1, data_oe=0 for N_INH clks.
  - On terminal count, set data_oe=1 (start bit 0) while clock_oe is still 1; go to REQ.
- REQ:
  - Lasts exactly 1 clk with both oe=1, then clock_oe=0.
  - Load the counter with N_ST; go to WAIT_CLK.
- WAIT_CLK:
  - On the first falling edge: data_oe = ~bit0, bitcnt=1, load the counter with N_XF, go to SHIFT.
  - Counter expiry goes to TMO.
- SHIFT:
  - Each falling edge advances bitcnt.
  - Falling edges 2..8 set data_oe = ~bit[1..7], LSB first.
  - Edge 9 sets data_oe = ~par.
  - Edge 10 sets data_oe=0 (stop bit, line released).
  - Edge 11 samples data: 0 means success, 1 sets ack_err. Either way go to FINISH.
  - Counter expiry goes to TMO.
- TMO:
  - Both oe=0, timeout=1, go to FINISH.
- FINISH:
  - done=1 for 1 clk, busy=0 next clk, return to IDLE.
- No edge is interpreted outside WAIT_CLK/SHIFT, so device-originated traffic in IDLE is left to the receiver.
- Simultaneous falling edge and counter expiry in the same clk: the edge wins.

Test Plan:
1. Reset, then wr_stb with wr_data=0xED and clk0=1; a device model clocks at 12 kHz and ACKs. Required:
   - clock_oe high for exactly 6000 clks; data_oe rises 1 clk before clock_oe falls.
   - Data bits sampled on device rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
   - done pulses once; ack_err=0, timeout=0, busy cleared.
2. Send 0x00 then 0x01. Required: parity bits 1 and 0 respectively, with all data bits otherwise correct.
3. Send 0xFF with the device model holding data high at edge 11 (no ACK). Required: ack_err=1, done pulse, both oe=0.
4. Send 0xF4 with a silent device (no clocks after release). Required: timeout=1 exactly 750000 clks after clock release, done pulse, lines released, busy=0.
5. Assert wr_stb with 0xAA during SHIFT. Required: ignored; the original byte completes unchanged and a single done pulse occurs.
6. Pulse n_res low at edge 5 of a transfer. Required: both oe drop to 0 asynchronously and busy=0. A following write of 0xED then completes normally.

Source files
------------

// File: rtl/ps2_transmitter.sv
// rtl/ps2_transmitter.sv - host-to-device PS/2 byte transmitter with request-to-send sequencing
//
// Ports:
//   clk           system clock (CLK_HZ)
//   n_res         asynchronous active-low reset
//   clk0          CPU-clock phase qualifier; writes are taken only while high
//   wr_stb        write request from the I/O decode
//   wr_data       byte to send to the device
//   ps2_clock_in  raw PS/2 clock pin level (asynchronous)
//   ps2_data_in   raw PS/2 data pin level (asynchronous)
//   ps2_clock_oe  1 pulls the clock pin low, 0 releases it
//   ps2_data_oe   1 pulls the data pin low, 0 releases it
//   busy          transfer in progress (receiver should ignore device clocks)
//   done          one-clk pulse at the end of every transfer
//   ack_err       sticky: device did not acknowledge
//   timeout       sticky: device did not clock in time

module ps2_transmitter #(
   parameter int CLK_HZ      = 50000000,
   parameter int INHIBIT_US  = 120,
   parameter int START_TO_US = 15000,
   parameter int XFER_TO_US  = 2000
) (
   input  logic       clk,
   input  logic       n_res,
   input  logic       clk0,
   input  logic       wr_stb,
   input  logic [7:0] wr_data,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int CYC_PER_US = CLK_HZ / 1000000;
   localparam int N_INH      = CYC_PER_US * INHIBIT_US;
   localparam int N_ST       = CYC_PER_US * START_TO_US;
   localparam int N_XF       = CYC_PER_US * XFER_TO_US;
   localparam int N_MAX_A    = (N_INH > N_ST) ? N_INH : N_ST;
   localparam int N_MAX      = (N_MAX_A > N_XF) ? N_MAX_A : N_XF;
   localparam int CW         = $clog2(N_MAX + 1);

   // INHIBIT holds N_INH-1 clks with data released; the REQ clk completes
   // the N_INH-clk clock-low window with the start bit already driven.
   localparam logic [CW-1:0] LD_INH = CW'(N_INH - 2);
   localparam logic [CW-1:0] LD_ST  = CW'(N_ST - 1);
   localparam logic [CW-1:0] LD_XF  = CW'(N_XF - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_INHIBIT  = 3'd1;
   localparam logic [2:0] S_REQ      = 3'd2;
   localparam logic [2:0] S_WAIT_CLK = 3'd3;
   localparam logic [2:0] S_SHIFT    = 3'd4;
   localparam logic [2:0] S_TMO      = 3'd5;
   localparam logic [2:0] S_FINISH   = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic          clock_oe_q, clock_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          busy_q, busy_d;
   logic          ack_err_q, ack_err_d;
   logic          timeout_q, timeout_d;
   logic          clk_s1_q, clk_s2_q, clk_prev_q;
   logic          dat_s1_q, dat_s2_q;
   logic          fall;

   assign fall = clk_prev_q & ~clk_s2_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      clock_oe_d = clock_oe_q;
      data_oe_d  = data_oe_q;
      busy_d     = busy_q;
      ack_err_d  = ack_err_q;
      timeout_d  = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (wr_stb & clk0) begin
               shreg_d    = wr_data;
               par_d      = ~^wr_data;
               ack_err_d  = 1'b0;
               timeout_d  = 1'b0;
               busy_d     = 1'b1;
               clock_oe_d = 1'b1;
               data_oe_d  = 1'b0;
               bitcnt_d   = 4'd0;
               cnt_d      = LD_INH;
               state_d    = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == '0) begin
               data_oe_d = 1'b1;
               state_d   = S_REQ;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_REQ: begin
            clock_oe_d = 1'b0;
            cnt_d      = LD_ST;
            state_d    = S_WAIT_CLK;
         end
         S_WAIT_CLK: begin
            if (fall) begin
               data_oe_d = ~shreg_q[0];
               bitcnt_d  = 4'd1;
               cnt_d     = LD_XF;
               state_d   = S_SHIFT;
            end else if (cnt_q == '0) begin
               clock_oe_d = 1'b0;
               data_oe_d  = 1'b0;
               timeout_d  = 1'b1;
               state_d    = S_TMO;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end
            // An edge arriving on the expiry clk still counts.
            if (fall) begin
               bitcnt_d = bitcnt_q + 4'd1;
               case (bitcnt_q)
                  4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: data_oe_d = ~shreg_q[bitcnt_q[2:0]];
                  4'd8:    data_oe_d = ~par_q;
                  4'd9:    data_oe_d = 1'b0;
                  default: begin
                     if (dat_s2_q) begin
                        ack_err_d = 1'b1;
                     end
                     state_d = S_FINISH;
                  end
               endcase
            end else if (cnt_q == '0) begin
               clock_oe_d = 1'b0;
               data_oe_d  = 1'b0;
               timeout_d  = 1'b1;
               state_d    = S_TMO;
            end
         end
         S_TMO: begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            timeout_d  = 1'b1;
            state_d    = S_FINISH;
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_res) begin
      if (!n_res) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bitcnt_q   <= 4'd0;
         shreg_q    <= 8'd0;
         par_q      <= 1'b0;
         clock_oe_q <= 1'b0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
         // Idle bus level is high; starting high avoids a false edge.
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         clock_oe_q <= clock_oe_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         ack_err_q  <= ack_err_d;
         timeout_q  <= timeout_d;
         clk_s1_q   <= ps2_clock_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data_in;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign ps2_clock_oe = clock_oe_q;
   assign ps2_data_oe  = data_oe_q;
   assign busy         = busy_q;
   assign done         = (state_q == S_FINISH);
   assign ack_err      = ack_err_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb/tb_ps2_transmitter.sv - self-checking bench for ps2_transmitter with a PS/2 device model

module tb_ps2_transmitter;

   localparam int CLK_HZ = 1000000;
   localparam int INH_US = 120;
   localparam int ST_US  = 3000;
   localparam int XF_US  = 2000;
   localparam int N_INH  = (CLK_HZ / 1000000) * INH_US;
   localparam int N_ST   = (CLK_HZ / 1000000) * ST_US;
   localparam int H      = 40;

   logic       clk = 1'b0;
   logic       n_res = 1'b0;
   logic       clk0 = 1'b0;
   logic       wr_stb = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clock_in, ps2_data_in;
   logic       ps2_clock_oe, ps2_data_oe, busy, done, ack_err, timeout;

   // Open-drain bus with pull-ups: low if either side pulls low.
   assign ps2_clock_in = ~ps2_clock_oe & dev_clk;
   assign ps2_data_in  = ~ps2_data_oe & dev_data;

   ps2_transmitter #(
      .CLK_HZ(CLK_HZ), .INHIBIT_US(INH_US), .START_TO_US(ST_US), .XFER_TO_US(XF_US)
   ) dut (
      .clk(clk), .n_res(n_res), .clk0(clk0), .wr_stb(wr_stb), .wr_data(wr_data),
      .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
      .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe),
      .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;
   bit   exp_bits[$];
   logic [1:0] exp_res[$];

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [7:0] b, input bit push_bits, input bit e_ack, input bit e_tmo);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      if (push_bits) begin
         for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
         exp_bits.push_back((ones % 2) == 0);
         exp_bits.push_back(1'b1);
      end
      exp_res.push_back({e_ack, e_tmo});
      done_cnt = 0;
      @(negedge clk);
      wr_data = b; wr_stb = 1'b1; clk0 = 1'b1;
      @(negedge clk);
      wr_stb = 1'b0; clk0 = 1'b0;
   endtask

   task automatic measure_inhibit();
      int n = 0, dn = 0, last_d = -1;
      while (ps2_clock_oe === 1'b1 && n < N_INH + 10) begin
         if (ps2_data_oe === 1'b1) begin dn++; last_d = n; end
         n++;
         @(negedge clk);
      end
      tests++;
      if (n !== N_INH) begin fails++; $display("FAIL inhibit_len: got %0d want %0d", n, N_INH); end
      tests++;
      if (dn !== 1 || last_d !== n - 1) begin
         fails++; $display("FAIL start_lead: data_oe clks %0d at %0d, want 1 at %0d", dn, last_d, n - 1);
      end
      tests++;
      if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL start_held: data_oe %b busy %b want 1 1", ps2_data_oe, busy);
      end
   endtask

   // Device: 11 clock pulses, samples data on rising edges 1..10, ACKs before edge 11.
   task automatic device_run(input int abort_at, input int inject_at, input bit ack);
      bit e;
      repeat (20) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         for (int c = 0; c < H; c++) begin
            @(negedge clk);
            if (k == inject_at && c == 5) begin wr_data = 8'hAA; wr_stb = 1'b1; clk0 = 1'b1; end
            if (k == inject_at && c == 6) begin wr_stb = 1'b0; clk0 = 1'b0; end
         end
         if (k == abort_at) begin
            #2 n_res = 1'b0;
            #1;
            tests++;
            if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
               fails++;
               $display("FAIL async_reset: oe %b%b busy %b want 00 0", ps2_clock_oe, ps2_data_oe, busy);
            end
            @(negedge clk);
            n_res = 1'b1; dev_clk = 1'b1; dev_data = 1'b1;
            exp_bits.delete(); exp_res.delete();
            return;
         end
         dev_clk = 1'b1;
         if (k <= 10) begin
            tests++;
            if (exp_bits.size() == 0) begin
               fails++; $display("FAIL bit%0d: got %b want (queue empty)", k, ps2_data_in);
            end else begin
               e = exp_bits.pop_front();
               if (ps2_data_in !== e) begin fails++; $display("FAIL bit%0d: got %b want %b", k, ps2_data_in, e); end
            end
         end
         if (k == 10 && ack) begin
            repeat (H / 2) @(negedge clk);
            dev_data = 1'b0;
            repeat (H - H / 2) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
      end
      dev_data = 1'b1;
   endtask

   task automatic check_done(input string name);
      logic [1:0] r;
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      r = (exp_res.size() != 0) ? exp_res.pop_front() : 2'bxx;
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy: got %b want 0", name, busy); end
      tests++;
      if (done_cnt !== 1) begin fails++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt); end
      tests++;
      if ({ack_err, timeout} !== r) begin
         fails++; $display("FAIL %s_flags: ack_err,timeout got %b want %b", name, {ack_err, timeout}, r);
      end
      tests++;
      if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0 || exp_bits.size() != 0) begin
         fails++;
         $display("FAIL %s_release: oe %b%b left bits %0d want 00 0", name, ps2_clock_oe, ps2_data_oe, exp_bits.size());
      end
   endtask

   task automatic run_xfer(input logic [7:0] b, input bit ack, input string name);
      do_write(b, 1'b1, ~ack, 1'b0);
      measure_inhibit();
      device_run(0, 0, ack);
      check_done(name);
   endtask

   task automatic test_reset();
      n_res = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({ps2_clock_oe, ps2_data_oe, busy, done, ack_err, timeout} !== 6'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {ps2_clock_oe, ps2_data_oe, busy, done, ack_err, timeout});
      end
      n_res = 1'b1;
      @(negedge clk);
      wr_data = 8'h55; wr_stb = 1'b1; clk0 = 1'b0;
      @(negedge clk);
      wr_stb = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || ps2_clock_oe !== 1'b0) begin
         fails++; $display("FAIL clk0_gate: busy %b clock_oe %b want 0 0", busy, ps2_clock_oe);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      do_write(8'hF4, 1'b0, 1'b0, 1'b1);
      measure_inhibit();
      while (timeout !== 1'b1 && n < N_ST + 50) begin @(negedge clk); n++; end
      tests++;
      if (n !== N_ST) begin fails++; $display("FAIL timeout_len: got %0d want %0d", n, N_ST); end
      check_done("timeout");
   endtask

   task automatic test_ignore_busy_write();
      do_write(8'hED, 1'b1, 1'b0, 1'b0);
      measure_inhibit();
      device_run(0, 5, 1'b1);
      check_done("ignore_wr");
   endtask

   task automatic test_reset_mid();
      do_write(8'hED, 1'b1, 1'b0, 1'b0);
      measure_inhibit();
      device_run(5, 0, 1'b1);
      repeat (5) @(negedge clk);
      tests++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         fails++; $display("FAIL reset_no_done: done %0d busy %b want 0 0", done_cnt, busy);
      end
      run_xfer(8'hED, 1'b1, "after_reset");
   endtask

   initial begin
      test_reset();
      run_xfer(8'hED, 1'b1, "xfer_ed");
      run_xfer(8'h00, 1'b1, "xfer_00");
      run_xfer(8'h01, 1'b1, "xfer_01");
      run_xfer(8'hFF, 1'b0, "no_ack");
      test_timeout();
      test_ignore_busy_write();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
